// File: rtl/pkg_dtypes.sv
// Shared datatypes for the execution-unit issue path.
//   type_iqueue_entry    : one instruction-queue entry as seen at a sub-queue head
//   type_issue_arb_state : issue arbiter drain FSM states
package pkg_dtypes;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [5:0]  dest_tag;
        logic [17:0] operand;
    } type_iqueue_entry;

    typedef enum logic [1:0] {
        ArbRun     = 2'd0,
        ArbDrain   = 2'd1,
        ArbDrained = 2'd2
    } type_issue_arb_state;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker (purely combinational).
//   req_i       : request vector, one bit per requester
//   ptr_i       : highest-priority requester index; search proceeds upward, wrapping
//   grant_o     : one-hot grant (all zero when no request)
//   any_grant_o : at least one requester was granted
module rr_priority_picker #(
    parameter int unsigned LOG2_N = 2,
    localparam int unsigned N = 2 ** LOG2_N
) (
    input  logic [N-1:0]      req_i,
    input  logic [LOG2_N-1:0] ptr_i,
    output logic [N-1:0]      grant_o,
    output logic              any_grant_o
);

    logic [LOG2_N-1:0] idx;

    always_comb begin
        grant_o     = '0;
        any_grant_o = 1'b0;
        idx         = '0;
        for (int unsigned i = 0; i < N; i++) begin
            // N is a power of two, so the index wraps naturally at LOG2_N bits
            idx = ptr_i + LOG2_N'(i);
            if (!any_grant_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                any_grant_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eu_issue_arbiter.sv
// Execution-unit issue arbiter: round-robin selects one sub-queue head per cycle
// into a registered output slot, with drain and flush control.
//   clk, reset      : clock, synchronous active-high reset
//   head_valid_i    : per sub-queue head-valid
//   head_data_i     : per sub-queue head entry
//   head_pop_o      : one-hot pop strobe, entry consumed this cycle
//   issue_o         : registered entry to the execution unit
//   issue_valid_o   : issue_o valid
//   issue_ready_i   : execution unit accepts issue_o
//   drain_req_i     : level request to stop granting and empty the slot
//   drained_o       : slot empty and drain acknowledged
//   flush_i         : discard held entry, reset round-robin pointer
//   issued_cnt_o    : handshake counter, wraps
module eu_issue_arbiter
    import pkg_dtypes::*;
#(
    parameter int unsigned EU_LOG2_IQUEUE_NUM_QUEUES = 2,
    parameter int unsigned CNT_WIDTH                 = 16,
    localparam int unsigned NUM_REQ                  = 2 ** EU_LOG2_IQUEUE_NUM_QUEUES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic             [NUM_REQ-1:0]      head_valid_i,
    input  type_iqueue_entry [NUM_REQ-1:0]      head_data_i,
    output logic             [NUM_REQ-1:0]      head_pop_o,
    output type_iqueue_entry                    issue_o,
    output logic                                issue_valid_o,
    input  logic                                issue_ready_i,
    input  logic                                drain_req_i,
    output logic                                drained_o,
    input  logic                                flush_i,
    output logic             [CNT_WIDTH-1:0]    issued_cnt_o
);

    localparam int unsigned PtrW = EU_LOG2_IQUEUE_NUM_QUEUES;

    type_issue_arb_state state_q;
    logic [PtrW-1:0]     rr_ptr_q;
    type_iqueue_entry    issue_q;
    logic                issue_valid_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                slot_free;
    logic                handshake;
    logic                grant_en;
    logic                grant_take;
    logic [NUM_REQ-1:0]  pick_grant;
    logic                pick_any;
    logic [PtrW-1:0]     grant_idx;
    logic                issue_valid_d;

    rr_priority_picker #(
        .LOG2_N (PtrW)
    ) u_picker (
        .req_i       (head_valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (pick_grant),
        .any_grant_o (pick_any)
    );

    always_comb begin
        slot_free  = ~issue_valid_q | issue_ready_i;
        handshake  = issue_valid_q & issue_ready_i;
        // Flush and reset both suppress the pop so no entry is lost from a sub-queue
        grant_en   = (state_q == ArbRun) & slot_free & ~flush_i & ~reset;
        grant_take = grant_en & pick_any;
        head_pop_o = grant_en ? pick_grant : '0;

        grant_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                grant_idx = PtrW'(i);
            end
        end

        if (flush_i) begin
            issue_valid_d = 1'b0;
        end else if (grant_take) begin
            issue_valid_d = 1'b1;
        end else if (slot_free) begin
            issue_valid_d = 1'b0;
        end else begin
            issue_valid_d = issue_valid_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ArbRun;
            rr_ptr_q      <= '0;
            issue_q       <= '0;
            issue_valid_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            if (handshake) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end

            issue_valid_q <= issue_valid_d;

            if (flush_i) begin
                rr_ptr_q <= '0;
            end else if (grant_take) begin
                issue_q  <= head_data_i[grant_idx];
                rr_ptr_q <= grant_idx + PtrW'(1);
            end

            // Drain completes once the slot will be empty after this edge
            if (!flush_i) begin
                unique case (state_q)
                    ArbRun: begin
                        if (drain_req_i) state_q <= ArbDrain;
                    end
                    ArbDrain: begin
                        if (!drain_req_i)        state_q <= ArbRun;
                        else if (!issue_valid_d) state_q <= ArbDrained;
                    end
                    ArbDrained: begin
                        if (!drain_req_i) state_q <= ArbRun;
                    end
                    default: state_q <= ArbRun;
                endcase
            end
        end
    end

    assign issue_o       = issue_q;
    assign issue_valid_o = issue_valid_q;
    assign issued_cnt_o  = cnt_q;
    assign drained_o     = (state_q == ArbDrained);

endmodule

// File: tb/tb_eu_issue_arbiter.sv
module tb_eu_issue_arbiter;
    import pkg_dtypes::*;

    logic                   clk;
    logic                   rst;
    logic [3:0]             hv;
    type_iqueue_entry [3:0] hdata;
    logic [3:0]             pop;
    type_iqueue_entry       iss;
    logic                   iss_valid;
    logic                   rdy;
    logic                   drain;
    logic                   drained;
    logic                   flush;
    logic [15:0]            cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state (0 = run, 1 = drain, 2 = drained)
    int               m_state;
    int               m_ptr;
    bit               m_valid;
    type_iqueue_entry m_data;
    logic [15:0]      m_cnt;
    logic [3:0]       last_pop;

    eu_issue_arbiter #(
        .EU_LOG2_IQUEUE_NUM_QUEUES (2),
        .CNT_WIDTH                 (16)
    ) dut (
        .clk           (clk),
        .reset         (rst),
        .head_valid_i  (hv),
        .head_data_i   (hdata),
        .head_pop_o    (pop),
        .issue_o       (iss),
        .issue_valid_o (iss_valid),
        .issue_ready_i (rdy),
        .drain_req_i   (drain),
        .drained_o     (drained),
        .flush_i       (flush),
        .issued_cnt_o  (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) hdata[i] = type_iqueue_entry'($urandom);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_cnt   = '0;
    endtask

    // One clock cycle: predict, compare mid-cycle, then advance the model at the edge.
    task automatic step();
        int         p;
        logic [3:0] exp_pop;
        bit         free;
        p    = -1;
        free = !m_valid || rdy;
        if (!rst && m_state == 0 && free && !flush) begin
            for (int k = 0; k < 4; k++) begin
                if (p < 0 && hv[(m_ptr + k) % 4]) p = (m_ptr + k) % 4;
            end
        end
        exp_pop = 4'b0000;
        if (p >= 0) exp_pop[p] = 1'b1;

        @(negedge clk);
        check("head_pop", 32'(pop), 32'(exp_pop));
        check("issue_valid", 32'(iss_valid), 32'(m_valid));
        check("drained", 32'(drained), 32'(m_state == 2));
        check("issued_cnt", 32'(cnt), 32'(m_cnt));
        if (m_valid) check("issue_data", iss, m_data);
        last_pop = pop;

        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            bit nv;
            if (m_valid && rdy) m_cnt = m_cnt + 16'd1;
            if (flush) begin
                nv    = 1'b0;
                m_ptr = 0;
            end else if (p >= 0) begin
                nv     = 1'b1;
                m_data = hdata[p];
                m_ptr  = (p + 1) % 4;
            end else if (free) begin
                nv = 1'b0;
            end else begin
                nv = m_valid;
            end
            m_valid = nv;
            if (!flush) begin
                case (m_state)
                    0: if (drain) m_state = 1;
                    1: if (!drain) m_state = 0; else if (!nv) m_state = 2;
                    default: if (!drain) m_state = 0;
                endcase
            end
        end
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        hv    = 4'b0000;
        rdy   = 1'b0;
        drain = 1'b0;
        flush = 1'b0;
        randomize_data();
        model_reset();
        @(posedge clk);
        #1;
        step();
        check("reset_valid", 32'(iss_valid), 32'd0);
        check("reset_cnt", 32'(cnt), 32'd0);
        check("reset_data", iss, 32'd0);

        // All heads valid, ready high: pops walk 0,1,2,3,0
        rst = 1'b0;
        hv  = 4'b1111;
        rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            randomize_data();
            step();
            check("rr_order", 32'(last_pop), 32'(1 << (i % 4)));
        end
        hv = 4'b0000;
        step();
        check("cnt_after5", 32'(cnt), 32'd5);

        // Heads 1 and 3 only, pointer at 2: grant 3 then 1
        flush = 1'b1;
        step();
        flush = 1'b0;
        hv    = 4'b0010;
        step();
        check("ptr_setup", 32'(last_pop), 32'h2);
        hv = 4'b1010;
        randomize_data();
        step();
        check("sparse_first", 32'(last_pop), 32'h8);
        randomize_data();
        step();
        check("sparse_second", 32'(last_pop), 32'h2);
        hv = 4'b0000;
        step();

        // Back-pressure: entry held stable, no pops, then handshake and new grant together
        hv = 4'b1111;
        randomize_data();
        step();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_data();
            step();
            check("stall_nopop", 32'(last_pop), 32'd0);
        end
        rdy = 1'b1;
        step();
        check("stall_release", 32'(last_pop != 4'b0000), 32'd1);

        // Drain with entry held
        rdy   = 1'b0;
        drain = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("drain_nopop", 32'(last_pop), 32'd0);
        end
        rdy = 1'b1;
        step();
        check("drain_accept_nopop", 32'(last_pop), 32'd0);
        check("drained_next", 32'(drained), 32'd1);
        step();
        drain = 1'b0;
        step();
        step();
        check("drain_resume", 32'(last_pop != 4'b0000), 32'd1);

        // Flush with pointer at 3 and entry held
        flush = 1'b1;
        hv    = 4'b0000;
        step();
        flush = 1'b0;
        hv    = 4'b0100;
        rdy   = 1'b0;
        step();
        hv    = 4'b1111;
        flush = 1'b1;
        step();
        check("flush_nopop", 32'(last_pop), 32'd0);
        check("flush_valid", 32'(iss_valid), 32'd0);
        flush = 1'b0;
        rdy   = 1'b1;
        step();
        check("flush_ptr0", 32'(last_pop), 32'h1);

        // Reset while an entry is held
        rst = 1'b1;
        step();
        check("midreset_valid", 32'(iss_valid), 32'd0);
        check("midreset_cnt", 32'(cnt), 32'd0);
        check("midreset_drained", 32'(drained), 32'd0);
        rst = 1'b0;

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            hv    = 4'($urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 24) == 0) drain = ~drain;
            randomize_data();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
